// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// The FSM state enum and the mode encodings live here.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COUNT  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser for one asynchronous ring-oscillator line, followed by
// a registered rising-edge detector that emits a one-cycle pulse per edge.
module ro_edge_sync (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic d_i,
    output logic rise_o
);

    // [0],[1] form the synchroniser; [2] holds the previous synchronised value
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d_i};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: selects one RO channel, discards a few settle
// cycles, then counts its rising edges over a gate window in single/continuous/scan modes.
module ro_freq_meter
    import ro_meas_pkg::*;
#(
    parameter int N_RO   = 16,
    parameter int SEL_W  = 4,
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [N_RO-1:0]   ro_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [1:0]        mode_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [GATE_W-1:0] gate_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [SEL_W-1:0]  chan_o,
    output logic              ovf_o
);

    localparam int                N_PAD       = 1 << SEL_W;
    localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0]  CHAN_LAST   = SEL_W'(N_RO - 1);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [SEL_W-1:0]  chan_q, chan_d;
    logic [GATE_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              edge_ovf_q, edge_ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  res_chan_q, res_chan_d;
    logic              res_ovf_q, res_ovf_d;
    logic              valid_q, valid_d;

    logic [N_PAD-1:0]  ro_pad;
    logic              ro_sel;
    logic              rise;
    logic [GATE_W-1:0] gate_last;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_inc;

    // Unpopulated channel codes read as a constant 0, so they measure zero edges
    for (genvar gi = 0; gi < N_PAD; gi++) begin : g_pad
        if (gi < N_RO) begin : g_in
            assign ro_pad[gi] = ro_i[gi];
        end else begin : g_zero
            assign ro_pad[gi] = 1'b0;
        end
    end

    assign ro_sel    = ro_pad[chan_q];
    assign gate_last = (gate_q == '0) ? '0 : gate_q - GATE_W'(1);

    ro_edge_sync u_sync (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .d_i      (ro_sel),
        .rise_o   (rise)
    );

    // An edge arriving while the counter is all-ones is lost and flags overflow
    always_comb begin
        cnt_inc = edge_cnt_q;
        ovf_inc = edge_ovf_q;
        if (rise) begin
            if (&edge_cnt_q) begin
                ovf_inc = 1'b1;
            end else begin
                cnt_inc = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        gate_d     = gate_q;
        chan_d     = chan_q;
        tmr_d      = tmr_q;
        edge_cnt_d = edge_cnt_q;
        edge_ovf_d = edge_ovf_q;
        cnt_d      = cnt_q;
        res_chan_d = res_chan_q;
        res_ovf_d  = res_ovf_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    mode_d  = mode_i;
                    gate_d  = gate_i;
                    chan_d  = (mode_i == MODE_SCAN) ? '0 : sel_i;
                    tmr_d   = SETTLE_LAST;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                edge_cnt_d = '0;
                edge_ovf_d = 1'b0;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (tmr_q == '0) begin
                    tmr_d   = gate_last;
                    state_d = S_COUNT;
                end else begin
                    tmr_d = tmr_q - GATE_W'(1);
                end
            end
            S_COUNT: begin
                edge_cnt_d = cnt_inc;
                edge_ovf_d = ovf_inc;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (tmr_q == '0) begin
                    // Result registers load with the final edge included, so they line up with valid_o
                    cnt_d      = cnt_inc;
                    res_chan_d = chan_q;
                    res_ovf_d  = ovf_inc;
                    valid_d    = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    tmr_d = tmr_q - GATE_W'(1);
                end
            end
            S_DONE: begin
                tmr_d = SETTLE_LAST;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (mode_q == MODE_CONT) begin
                    state_d = S_SETTLE;
                end else if (mode_q == MODE_SCAN && chan_q != CHAN_LAST) begin
                    chan_d  = chan_q + SEL_W'(1);
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_SINGLE;
            gate_q     <= '0;
            chan_q     <= '0;
            tmr_q      <= '0;
            edge_cnt_q <= '0;
            edge_ovf_q <= 1'b0;
            cnt_q      <= '0;
            res_chan_q <= '0;
            res_ovf_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            gate_q     <= gate_d;
            chan_q     <= chan_d;
            tmr_q      <= tmr_d;
            edge_cnt_q <= edge_cnt_d;
            edge_ovf_q <= edge_ovf_d;
            cnt_q      <= cnt_d;
            res_chan_q <= res_chan_d;
            res_ovf_q  <= res_ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;
    assign chan_o  = res_chan_q;
    assign ovf_o   = res_ovf_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: two instances (16 ch / 16-bit count, 12 ch / 4-bit count)
// share stimulus and are checked every cycle against a result-schedule model.
module tb_ro_freq_meter;

    localparam int NA = 16;
    localparam int WA = 16;
    localparam int NB = 12;
    localparam int WB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ro = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  sel = '0;
    logic [15:0] gate = '0;

    logic        busy_a, valid_a, ovf_a;
    logic [15:0] cnt_a;
    logic [3:0]  chan_a;
    logic        busy_b, valid_b, ovf_b;
    logic [3:0]  cnt_b;
    logic [3:0]  chan_b;

    ro_freq_meter #(.N_RO(NA), .SEL_W(4), .GATE_W(16), .CNT_W(WA), .SETTLE(3)) u_dut_a (
        .wb_clk_i (clk),    .wb_rst_i (rst),    .ro_i    (ro),
        .start_i  (start),  .stop_i   (stop),   .mode_i  (mode),
        .sel_i    (sel),    .gate_i   (gate),   .busy_o  (busy_a),
        .valid_o  (valid_a), .cnt_o   (cnt_a),  .chan_o  (chan_a),
        .ovf_o    (ovf_a)
    );

    ro_freq_meter #(.N_RO(NB), .SEL_W(4), .GATE_W(16), .CNT_W(WB), .SETTLE(3)) u_dut_b (
        .wb_clk_i (clk),    .wb_rst_i (rst),    .ro_i    (ro[NB-1:0]),
        .start_i  (start),  .stop_i   (stop),   .mode_i  (mode),
        .sel_i    (sel),    .gate_i   (gate),   .busy_o  (busy_b),
        .valid_o  (valid_b), .cnt_o   (cnt_b),  .chan_o  (chan_b),
        .ovf_o    (ovf_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int period [16];
    int tests = 0;
    int fails = 0;

    typedef struct {
        int at;
        int chan;
        int cnt;
        int ovf;
    } res_t;

    res_t qa[$];
    res_t qb[$];
    int   bstart [2];
    int   bend [2];
    int   exp_cnt [2];
    int   exp_chan [2];
    int   exp_ovf [2];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // RO level during cycle n: square wave of the channel's period, phase-shifted per channel
    function automatic bit ro_val(input int k, input int n);
        int p;
        p = period[k];
        if (p == 0) return 1'b0;
        return ((n + 3 * k) % p) < (p / 2);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 16; k++) ro[k] = ro_val(k, cyc);
    end

    // A window that starts from cycle c counts rising edges first sampled in
    // cycles c+2 .. c+1+g: the synchroniser delays each edge by two cycles
    // relative to the settle/count phases.
    function automatic void model_count(input int n_ro, input int w, input int ch,
                                        input int c, input int g,
                                        output int cnt, output int ovf);
        int maxv;
        maxv = (1 << w) - 1;
        cnt  = 0;
        ovf  = 0;
        if (ch >= n_ro) return;
        for (int k = c + 2; k <= c + 1 + g; k++) begin
            if (ro_val(ch, k) && !ro_val(ch, k - 1)) begin
                if (cnt == maxv) ovf = 1;
                else cnt++;
            end
        end
    endfunction

    task automatic schedule(input int i, input int c);
        int   n_ro, w, g, ch, t, nres;
        res_t r;
        n_ro = (i == 0) ? NA : NB;
        w    = (i == 0) ? WA : WB;
        g    = (gate == 16'd0) ? 1 : int'(gate);
        ch   = (mode == 2'b10) ? 0 : int'(sel);
        nres = (mode == 2'b01) ? 64 : (mode == 2'b10) ? n_ro : 1;
        t    = c;
        for (int j = 0; j < nres; j++) begin
            r.at   = t + 4 + g;
            r.chan = ch;
            model_count(n_ro, w, ch, t, g, r.cnt, r.ovf);
            if (i == 0) qa.push_back(r);
            else qb.push_back(r);
            t = r.at;
            if (mode == 2'b10) ch++;
        end
        bstart[i] = c + 1;
        bend[i]   = t;
    endtask

    task automatic truncate(input int i, input int s);
        if (i == 0) begin
            while (qa.size() > 0 && qa[qa.size() - 1].at > s) void'(qa.pop_back());
        end else begin
            while (qb.size() > 0 && qb[qb.size() - 1].at > s) void'(qb.pop_back());
        end
        bend[i] = s;
    endtask

    task automatic check_inst(input int i, input int busy, input int valid,
                              input int cnt, input int chan, input int ovf);
        res_t r;
        bit   ev;
        ev = 1'b0;
        if (i == 0) begin
            if (qa.size() > 0 && qa[0].at == cyc) begin r = qa.pop_front(); ev = 1'b1; end
        end else begin
            if (qb.size() > 0 && qb[0].at == cyc) begin r = qb.pop_front(); ev = 1'b1; end
        end
        if (ev) begin
            exp_cnt[i]  = r.cnt;
            exp_chan[i] = r.chan;
            exp_ovf[i]  = r.ovf;
        end
        chk($sformatf("busy%0d", i), busy, int'(cyc >= bstart[i] && cyc <= bend[i]));
        chk($sformatf("valid%0d", i), valid, int'(ev));
        chk($sformatf("cnt%0d", i), cnt, exp_cnt[i]);
        chk($sformatf("chan%0d", i), chan, exp_chan[i]);
        chk($sformatf("ovf%0d", i), ovf, exp_ovf[i]);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < 2; i++) begin
                bstart[i] = 0; bend[i] = -1;
                exp_cnt[i] = 0; exp_chan[i] = 0; exp_ovf[i] = 0;
            end
        end else begin
            check_inst(0, int'(busy_a), int'(valid_a), int'(cnt_a), int'(chan_a), int'(ovf_a));
            check_inst(1, int'(busy_b), int'(valid_b), int'(cnt_b), int'(chan_b), int'(ovf_b));
            for (int i = 0; i < 2; i++) begin
                if (cyc >= bstart[i] && cyc <= bend[i]) begin
                    if (stop) truncate(i, cyc);
                end else if (start && !stop) begin
                    schedule(i, cyc);
                end
            end
        end
    end

    task automatic go(input logic [1:0] m, input logic [3:0] s, input logic [15:0] g,
                      output int sc);
        @(posedge clk); #1;
        mode = m; sel = s; gate = g; stop = 1'b0; start = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid_a(input string name, input int budget, output int vc);
        bit found;
        found = 1'b0;
        vc    = -1;
        for (int j = 0; j < budget && !found; j++) begin
            @(negedge clk);
            if (valid_a) begin found = 1'b1; vc = cyc; end
        end
        chk({name, "_timeout"}, int'(found), 1);
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int j = 0; j < 6000 && !idle; j++) begin
            @(negedge clk);
            if (!busy_a && !busy_b) idle = 1'b1;
        end
        chk({name, "_idle_timeout"}, int'(idle), 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, vc, nv, cap, extra, idx;
        for (int k = 0; k < 16; k++) period[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_ovf", int'(ovf_a), 0);

        // 1: single measurement, ch5 at clk/8
        period[5] = 8;
        repeat (4) @(negedge clk);
        go(2'b00, 4'd5, 16'd100, sc);
        wait_valid_a("t1", 200, vc);
        chk("t1_latency", vc - sc, 104);
        chk("t1_cnt_12_or_13", int'(cnt_a inside {16'd12, 16'd13}), 1);
        chk("t1_chan", int'(chan_a), 5);
        chk("t1_ovf", int'(ovf_a), 0);
        wait_idle("t1");

        // 2: scan all channels, period 4*(k+1)
        for (int k = 0; k < 16; k++) period[k] = 4 * (k + 1);
        repeat (4) @(negedge clk);
        go(2'b10, 4'd9, 16'd240, sc);
        idx = 0;
        for (int j = 0; j < 5000 && busy_a; j++) begin
            @(negedge clk);
            if (valid_a) begin
                chk("t2_chan_order", int'(chan_a), idx);
                if (idx == 0) chk("t2_cnt_ch0", int'(cnt_a), 60);
                idx++;
            end
        end
        chk("t2_pulses", idx, 16);
        wait_idle("t2");
        chk("t2_busy_after", int'(busy_a), 0);

        // 3: saturation on the 4-bit instance, then an unsaturated run
        period[2] = 4;
        repeat (4) @(negedge clk);
        go(2'b00, 4'd2, 16'd200, sc);
        wait_valid_a("t3a", 300, vc);
        chk("t3_cnt_a", int'(cnt_a), 50);
        chk("t3_ovf_a", int'(ovf_a), 0);
        chk("t3_cnt_b_sat", int'(cnt_b), 15);
        chk("t3_ovf_b_sat", int'(ovf_b), 1);
        wait_idle("t3a");
        go(2'b00, 4'd2, 16'd20, sc);
        wait_valid_a("t3b", 100, vc);
        chk("t3_cnt_b", int'(cnt_b), 5);
        chk("t3_ovf_b_clear", int'(ovf_b), 0);
        wait_idle("t3b");

        // 4: continuous, three results, then abort mid-count; sel/gate changes are ignored
        period[3] = 8;
        repeat (4) @(negedge clk);
        go(2'b01, 4'd3, 16'd20, sc);
        sel  = 4'd7;
        gate = 16'd5;
        nv   = 0;
        cap  = 0;
        for (int j = 0; j < 400 && nv < 3; j++) begin
            @(negedge clk);
            if (valid_a) begin nv++; cap = int'(cnt_a); end
        end
        chk("t4_three_results", nv, 3);
        repeat (8) @(negedge clk);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        chk("t4_idle_after_stop", int'(busy_a), 0);
        extra = 0;
        repeat (60) begin @(negedge clk); if (valid_a) extra++; end
        chk("t4_no_more_valid", extra, 0);
        chk("t4_cnt_held", int'(cnt_a), cap);

        // 5a: gate 0 acts as a one-cycle window
        go(2'b00, 4'd2, 16'd0, sc);
        wait_valid_a("t5a", 20, vc);
        chk("t5_gate0_latency", vc - sc, 5);
        wait_idle("t5a");

        // 5b: channel 15 on the 12-channel instance reads zero
        period[15] = 4;
        repeat (4) @(negedge clk);
        go(2'b00, 4'd15, 16'd50, sc);
        wait_valid_a("t5b", 100, vc);
        chk("t5_oob_cnt_b", int'(cnt_b), 0);
        chk("t5_oob_chan_b", int'(chan_b), 15);
        wait_idle("t5b");

        // 5c: start while busy is ignored
        period[1] = 4;
        repeat (4) @(negedge clk);
        go(2'b00, 4'd1, 16'd60, sc);
        repeat (10) @(negedge clk);
        go(2'b00, 4'd2, 16'd5, vc);
        nv = 0;
        repeat (120) begin @(negedge clk); if (valid_a) nv++; end
        chk("t5_busy_start_ignored", nv, 1);
        wait_idle("t5c");

        // 5d: start and stop together leave the meter idle
        @(posedge clk); #1;
        mode = 2'b00; sel = 4'd1; gate = 16'd10; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("t5_start_stop_idle", int'(busy_a), 0);
        repeat (20) @(negedge clk);

        // 6: asynchronous reset mid-count, between clock edges
        go(2'b00, 4'd2, 16'd100, sc);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy_a", int'(busy_a), 0);
        chk("t6_cnt_a", int'(cnt_a), 0);
        chk("t6_chan_a", int'(chan_a), 0);
        chk("t6_valid_a", int'(valid_a), 0);
        chk("t6_busy_b", int'(busy_b), 0);
        chk("t6_cnt_b", int'(cnt_b), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nv = 0;
        repeat (150) begin @(negedge clk); if (valid_a || valid_b) nv++; end
        chk("t6_no_valid_after_reset", nv, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
